// File: rtl/tank_pkg.sv
// -----------------------------------------------------------------------------
// tank_pkg
// Shared definitions for the tank game datapath:
//   - tank / bullet direction codes
//   - bullet state encoding (also the value driven on the hit output)
//   - sprite and screen dimensions
// -----------------------------------------------------------------------------
package tank_pkg;

    // Direction codes; every other 3-bit value is invalid.
    localparam logic [2:0] DIR_UP    = 3'b001;
    localparam logic [2:0] DIR_RIGHT = 3'b010;
    localparam logic [2:0] DIR_LEFT  = 3'b011;
    localparam logic [2:0] DIR_DOWN  = 3'b100;

    // Bullet state; the encoding is exported directly as hit[1:0].
    // 2'b11 is deliberately unused.
    typedef enum logic [1:0] {
        HIT_IDLE   = 2'b00,
        HIT_FLIGHT = 2'b01,
        HIT_IMPACT = 2'b10
    } bullet_state_t;

    // Sprite and screen sizes in pixels.
    localparam int BULLET_SIZE = 8;
    localparam int TANK_SIZE   = 32;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;

endpackage

// File: rtl/bullet_ctrl_if.sv
// -----------------------------------------------------------------------------
// bullet_ctrl_if
// Groups the game-side signals of the bullet controller.
//   slave  : the bullet controller (consumes tank/enemy/wall/pixel info,
//            produces the bullet position, state and pixel/kill flags)
//   master : whoever drives the game inputs (game top or testbench)
// Signals:
//   frame_clk, fire                  vsync level, fire button level
//   tankX/tankY/tank_dir             owning tank top-left and direction
//   enemyX/enemyY/enemy_alive        opposing tank
//   wallX1..4/wallY1..4              wall top-left corners
//   DrawX/DrawY                      current VGA pixel
//   bulletX/bulletY/hit              bullet top-left and state
//   is_bullet/enemy_hit              pixel-in-bullet flag, one-cycle kill pulse
// -----------------------------------------------------------------------------
interface bullet_ctrl_if;
    logic       frame_clk;
    logic       fire;
    logic [9:0] tankX;
    logic [9:0] tankY;
    logic [2:0] tank_dir;
    logic [9:0] enemyX;
    logic [9:0] enemyY;
    logic       enemy_alive;
    logic [9:0] wallX1, wallX2, wallX3, wallX4;
    logic [9:0] wallY1, wallY2, wallY3, wallY4;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [9:0] bulletX;
    logic [9:0] bulletY;
    logic [1:0] hit;
    logic       is_bullet;
    logic       enemy_hit;

    modport slave (
        input  frame_clk, fire, tankX, tankY, tank_dir,
        input  enemyX, enemyY, enemy_alive,
        input  wallX1, wallX2, wallX3, wallX4,
        input  wallY1, wallY2, wallY3, wallY4,
        input  DrawX, DrawY,
        output bulletX, bulletY, hit, is_bullet, enemy_hit
    );

    modport master (
        output frame_clk, fire, tankX, tankY, tank_dir,
        output enemyX, enemyY, enemy_alive,
        output wallX1, wallX2, wallX3, wallX4,
        output wallY1, wallY2, wallY3, wallY4,
        output DrawX, DrawY,
        input  bulletX, bulletY, hit, is_bullet, enemy_hit
    );
endinterface

// File: rtl/rect_overlap.sv
// -----------------------------------------------------------------------------
// rect_overlap
// Combinational test of whether two axis-aligned boxes share at least one
// pixel. Boxes are inclusive: a box at x with width w covers x .. x+w-1.
// All arithmetic is 11 bits wide so box ends near the 10-bit limit do not wrap.
// Ports:
//   i_ax, i_ay, i_aw, i_ah   box A top-left and size (widths must be >= 1)
//   i_bx, i_by, i_bw, i_bh   box B top-left and size (widths must be >= 1)
//   o_overlap                1 when the boxes intersect
// -----------------------------------------------------------------------------
module rect_overlap (
    input  logic [10:0] i_ax,
    input  logic [10:0] i_ay,
    input  logic [10:0] i_aw,
    input  logic [10:0] i_ah,
    input  logic [10:0] i_bx,
    input  logic [10:0] i_by,
    input  logic [10:0] i_bw,
    input  logic [10:0] i_bh,
    output logic        o_overlap
);
    logic [10:0] w_ax_end;
    logic [10:0] w_ay_end;
    logic [10:0] w_bx_end;
    logic [10:0] w_by_end;

    assign w_ax_end = i_ax + i_aw - 11'd1;
    assign w_ay_end = i_ay + i_ah - 11'd1;
    assign w_bx_end = i_bx + i_bw - 11'd1;
    assign w_by_end = i_by + i_bh - 11'd1;

    assign o_overlap = (i_ax <= w_bx_end) && (i_bx <= w_ax_end) &&
                       (i_ay <= w_by_end) && (i_by <= w_ay_end);
endmodule

// File: rtl/bullet_ctrl.sv
// -----------------------------------------------------------------------------
// bullet_ctrl
// Controls one tank's bullet: spawns it in front of the tank on a fire press,
// moves it once per video frame, and ends the flight when it leaves the
// screen, hits the live enemy (kill pulse + impact animation) or hits a wall.
// Ports:
//   Clk    system clock (only clock)
//   Reset  synchronous, active-high
//   bus    bullet_ctrl_if.slave, see the interface for the signal list
// -----------------------------------------------------------------------------
module bullet_ctrl
    import tank_pkg::*;
#(
    parameter int BULLET_SPEED  = 4,
    parameter int IMPACT_FRAMES = 8,
    parameter int WALL_H_W      = 64,
    parameter int WALL_H_H      = 16,
    parameter int WALL_V_W      = 16,
    parameter int WALL_V_H      = 64
) (
    input  logic          Clk,
    input  logic          Reset,
    bullet_ctrl_if.slave  bus
);
    localparam int          CNT_W     = $clog2(IMPACT_FRAMES) + 1;
    localparam logic [10:0] SPEED     = 11'(BULLET_SPEED);
    localparam logic [10:0] B_SIZE    = 11'(BULLET_SIZE);
    localparam logic [10:0] B_LAST    = 11'(BULLET_SIZE - 1);
    localparam logic [10:0] T_SIZE    = 11'(TANK_SIZE);
    // Offset that centres the bullet across the tank's width/height.
    localparam logic [10:0] T_MID     = 11'((TANK_SIZE - BULLET_SIZE) / 2);
    localparam logic [10:0] X_MAX     = 11'(SCREEN_W - 1);
    localparam logic [10:0] Y_MAX     = 11'(SCREEN_H - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMPACT_FRAMES - 1);

    bullet_state_t    r_state, w_state_nxt;
    logic [9:0]       r_bx, r_by, w_bx_nxt, w_by_nxt;
    logic [2:0]       r_dir, w_dir_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_enemy_hit, w_enemy_hit_nxt;
    logic             r_pending;
    logic             r_fclk_s, r_fclk_p;
    logic             r_fire_s, r_fire_p;

    logic             w_tick;
    logic             w_fire_rise;

    // Edge detection on registered samples so the async-ish vsync and button
    // levels are only ever looked at through a flop.
    assign w_tick      = r_fclk_s & ~r_fclk_p;
    assign w_fire_rise = r_fire_s & ~r_fire_p;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fclk_s  <= 1'b0;
            r_fclk_p  <= 1'b0;
            r_fire_s  <= 1'b0;
            r_fire_p  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_fclk_s <= bus.frame_clk;
            r_fclk_p <= r_fclk_s;
            r_fire_s <= bus.fire;
            r_fire_p <= r_fire_s;
            // A press only arms a shot while no bullet is out; every frame
            // tick consumes the request whether or not a bullet spawned.
            if (w_tick)
                r_pending <= 1'b0;
            else if (w_fire_rise && (r_state == HIT_IDLE))
                r_pending <= 1'b1;
        end
    end

    // Spawn position in front of the tank. Underflow is checked before
    // subtracting so a tank hugging the top/left edge cannot wrap around.
    logic [10:0] w_tx, w_ty;
    logic [10:0] w_sp_x, w_sp_y;
    logic        w_sp_dir_ok;
    logic        w_sp_valid;

    assign w_tx = {1'b0, bus.tankX};
    assign w_ty = {1'b0, bus.tankY};

    always_comb begin
        w_sp_x      = '0;
        w_sp_y      = '0;
        w_sp_dir_ok = 1'b0;
        case (bus.tank_dir)
            DIR_UP: begin
                w_sp_x = w_tx + T_MID;
                if (w_ty >= B_SIZE) begin
                    w_sp_y      = w_ty - B_SIZE;
                    w_sp_dir_ok = 1'b1;
                end
            end
            DIR_DOWN: begin
                w_sp_x      = w_tx + T_MID;
                w_sp_y      = w_ty + T_SIZE;
                w_sp_dir_ok = 1'b1;
            end
            DIR_LEFT: begin
                w_sp_y = w_ty + T_MID;
                if (w_tx >= B_SIZE) begin
                    w_sp_x      = w_tx - B_SIZE;
                    w_sp_dir_ok = 1'b1;
                end
            end
            DIR_RIGHT: begin
                w_sp_x      = w_tx + T_SIZE;
                w_sp_y      = w_ty + T_MID;
                w_sp_dir_ok = 1'b1;
            end
            default: w_sp_dir_ok = 1'b0;
        endcase
    end

    assign w_sp_valid = w_sp_dir_ok &&
                        ((w_sp_x + B_LAST) <= X_MAX) &&
                        ((w_sp_y + B_LAST) <= Y_MAX);

    // Candidate next position for the flying bullet.
    logic [10:0] w_cx, w_cy;
    logic [10:0] w_nx, w_ny;
    logic        w_under;
    logic        w_leaves;

    assign w_cx = {1'b0, r_bx};
    assign w_cy = {1'b0, r_by};

    always_comb begin
        w_nx    = w_cx;
        w_ny    = w_cy;
        w_under = 1'b0;
        case (r_dir)
            DIR_UP: begin
                if (w_cy < SPEED) w_under = 1'b1;
                else              w_ny    = w_cy - SPEED;
            end
            DIR_DOWN:  w_ny = w_cy + SPEED;
            DIR_LEFT: begin
                if (w_cx < SPEED) w_under = 1'b1;
                else              w_nx    = w_cx - SPEED;
            end
            DIR_RIGHT: w_nx = w_cx + SPEED;
            default:   w_under = 1'b1;
        endcase
    end

    assign w_leaves = w_under ||
                      ((w_nx + B_LAST) > X_MAX) ||
                      ((w_ny + B_LAST) > Y_MAX);

    // Collision tests of the next bullet box against enemy and walls.
    logic w_ov_enemy;
    logic w_ov_w1, w_ov_w2, w_ov_w3, w_ov_w4;
    logic w_ov_wall;

    rect_overlap u_ov_enemy (
        .i_ax(w_nx), .i_ay(w_ny), .i_aw(B_SIZE), .i_ah(B_SIZE),
        .i_bx({1'b0, bus.enemyX}), .i_by({1'b0, bus.enemyY}),
        .i_bw(T_SIZE), .i_bh(T_SIZE),
        .o_overlap(w_ov_enemy)
    );

    rect_overlap u_ov_wall1 (
        .i_ax(w_nx), .i_ay(w_ny), .i_aw(B_SIZE), .i_ah(B_SIZE),
        .i_bx({1'b0, bus.wallX1}), .i_by({1'b0, bus.wallY1}),
        .i_bw(11'(WALL_H_W)), .i_bh(11'(WALL_H_H)),
        .o_overlap(w_ov_w1)
    );

    rect_overlap u_ov_wall2 (
        .i_ax(w_nx), .i_ay(w_ny), .i_aw(B_SIZE), .i_ah(B_SIZE),
        .i_bx({1'b0, bus.wallX2}), .i_by({1'b0, bus.wallY2}),
        .i_bw(11'(WALL_V_W)), .i_bh(11'(WALL_V_H)),
        .o_overlap(w_ov_w2)
    );

    rect_overlap u_ov_wall3 (
        .i_ax(w_nx), .i_ay(w_ny), .i_aw(B_SIZE), .i_ah(B_SIZE),
        .i_bx({1'b0, bus.wallX3}), .i_by({1'b0, bus.wallY3}),
        .i_bw(11'(WALL_H_W)), .i_bh(11'(WALL_H_H)),
        .o_overlap(w_ov_w3)
    );

    rect_overlap u_ov_wall4 (
        .i_ax(w_nx), .i_ay(w_ny), .i_aw(B_SIZE), .i_ah(B_SIZE),
        .i_bx({1'b0, bus.wallX4}), .i_by({1'b0, bus.wallY4}),
        .i_bw(11'(WALL_V_W)), .i_bh(11'(WALL_V_H)),
        .o_overlap(w_ov_w4)
    );

    assign w_ov_wall = w_ov_w1 | w_ov_w2 | w_ov_w3 | w_ov_w4;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= HIT_IDLE;
            r_bx        <= '0;
            r_by        <= '0;
            r_dir       <= '0;
            r_cnt       <= '0;
            r_enemy_hit <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bx        <= w_bx_nxt;
            r_by        <= w_by_nxt;
            r_dir       <= w_dir_nxt;
            r_cnt       <= w_cnt_nxt;
            r_enemy_hit <= w_enemy_hit_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bx_nxt        = r_bx;
        w_by_nxt        = r_by;
        w_dir_nxt       = r_dir;
        w_cnt_nxt       = r_cnt;
        w_enemy_hit_nxt = 1'b0;
        case (r_state)
            HIT_IDLE: begin
                if (w_tick && r_pending && w_sp_valid) begin
                    w_state_nxt = HIT_FLIGHT;
                    w_bx_nxt    = w_sp_x[9:0];
                    w_by_nxt    = w_sp_y[9:0];
                    w_dir_nxt   = bus.tank_dir;
                end
            end
            HIT_FLIGHT: begin
                // Screen exit beats enemy, enemy beats wall. Wall and screen
                // exits leave the bullet at its last on-screen position.
                if (w_tick) begin
                    if (w_leaves) begin
                        w_state_nxt = HIT_IDLE;
                    end else if (w_ov_enemy && bus.enemy_alive) begin
                        w_state_nxt     = HIT_IMPACT;
                        w_bx_nxt        = w_nx[9:0];
                        w_by_nxt        = w_ny[9:0];
                        w_cnt_nxt       = '0;
                        w_enemy_hit_nxt = 1'b1;
                    end else if (w_ov_wall) begin
                        w_state_nxt = HIT_IDLE;
                    end else begin
                        w_bx_nxt = w_nx[9:0];
                        w_by_nxt = w_ny[9:0];
                    end
                end
            end
            HIT_IMPACT: begin
                if (w_tick) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = HIT_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = HIT_IDLE;
        endcase
    end

    logic [10:0] w_dx, w_dy;
    assign w_dx = {1'b0, bus.DrawX};
    assign w_dy = {1'b0, bus.DrawY};

    assign bus.hit       = r_state;
    assign bus.bulletX   = r_bx;
    assign bus.bulletY   = r_by;
    assign bus.enemy_hit = r_enemy_hit;
    assign bus.is_bullet = (r_state == HIT_FLIGHT) &&
                           (w_dx >= w_cx) && (w_dx <= w_cx + B_LAST) &&
                           (w_dy >= w_cy) && (w_dy <= w_cy + B_LAST);
endmodule

// File: tb/tb_bullet_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bullet_ctrl
// Directed scenarios for bullet_ctrl. Stimulus pushes the expected bullet
// state into a queue and raises a strobe; a monitor pops and compares.
// Kill pulses are tracked by their own queue: each expected enemy_hit pulse
// cycle is pushed ahead of the triggering tick.
// -----------------------------------------------------------------------------
module tb_bullet_ctrl;

    typedef struct {
        string      name;
        logic [1:0] hit;
        logic [9:0] x;
        logic [9:0] y;
        logic       ib;
        bit         chk_pos;
    } exp_t;

    logic  Clk = 1'b0;
    logic  Reset;
    exp_t  exp_q[$];
    string kill_q[$];
    exp_t  mon_e;
    logic  chk_req = 1'b0;
    int    checks = 0;
    int    errors = 0;

    always #5 Clk = ~Clk;

    bullet_ctrl_if u_if ();

    bullet_ctrl #(
        .BULLET_SPEED(4), .IMPACT_FRAMES(8),
        .WALL_H_W(64), .WALL_H_H(16), .WALL_V_W(16), .WALL_V_H(64)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(u_if)
    );

    // Monitor: state comparisons on strobe, kill pulses whenever seen.
    always @(negedge Clk) begin
        if (chk_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: strobe with no expectation");
            end else begin
                mon_e = exp_q.pop_front();
                if ((u_if.hit !== mon_e.hit) || (u_if.is_bullet !== mon_e.ib) ||
                    (mon_e.chk_pos && ((u_if.bulletX !== mon_e.x) || (u_if.bulletY !== mon_e.y)))) begin
                    errors++;
                    $display("FAIL %s: got hit=%b pos=(%0d,%0d) is_bullet=%b, want hit=%b pos=(%0d,%0d)%s is_bullet=%b",
                             mon_e.name, u_if.hit, u_if.bulletX, u_if.bulletY, u_if.is_bullet,
                             mon_e.hit, mon_e.x, mon_e.y, mon_e.chk_pos ? "" : "(any)", mon_e.ib);
                end
            end
        end
        if (u_if.enemy_hit !== 1'b0) begin
            checks++;
            if (kill_q.size() == 0) begin
                errors++;
                $display("FAIL enemy_hit_unexpected: got enemy_hit=%b hit=%b, want 0", u_if.enemy_hit, u_if.hit);
            end else begin
                void'(kill_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic frame_tick();
        u_if.frame_clk = 1'b1;
        step(3);
        u_if.frame_clk = 1'b0;
        step(2);
    endtask

    task automatic press_fire();
        u_if.fire = 1'b1;
        step(3);
        u_if.fire = 1'b0;
        step(2);
    endtask

    task automatic set_tank(input logic [9:0] x, input logic [9:0] y, input logic [2:0] d);
        u_if.tankX    = x;
        u_if.tankY    = y;
        u_if.tank_dir = d;
    endtask

    task automatic expect_state(input string name, input logic [1:0] h,
                                input logic [9:0] x, input logic [9:0] y,
                                input logic [9:0] dx, input logic [9:0] dy,
                                input logic ib, input bit cp);
        exp_t e;
        e.name = name; e.hit = h; e.x = x; e.y = y; e.ib = ib; e.chk_pos = cp;
        u_if.DrawX = dx;
        u_if.DrawY = dy;
        exp_q.push_back(e);
        chk_req = 1'b1;
        step(1);
        chk_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        u_if.frame_clk = 1'b0; u_if.fire = 1'b0;
        set_tank(10'd0, 10'd0, 3'b000);
        u_if.enemyX = 10'd900; u_if.enemyY = 10'd900; u_if.enemy_alive = 1'b0;
        u_if.wallX1 = 10'd560; u_if.wallY1 = 10'd460;
        u_if.wallX2 = 10'd10;  u_if.wallY2 = 10'd400;
        u_if.wallX3 = 10'd300; u_if.wallY3 = 10'd0;
        u_if.wallX4 = 10'd10;  u_if.wallY4 = 10'd400;
        u_if.DrawX = 10'd0; u_if.DrawY = 10'd0;
        step(3);
        expect_state("reset_state", 2'b00, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b1);
        Reset = 1'b0;
        step(2);

        // Spawn right and move, then fire while flying.
        set_tank(10'd100, 10'd200, 3'b010);
        press_fire();
        frame_tick();
        expect_state("spawn_right", 2'b01, 10'd132, 10'd212, 10'd139, 10'd219, 1'b1, 1'b1);
        frame_tick();
        expect_state("move_right", 2'b01, 10'd136, 10'd212, 10'd135, 10'd212, 1'b0, 1'b1);
        press_fire();
        frame_tick();
        expect_state("fire_in_flight", 2'b01, 10'd140, 10'd212, 10'd140, 10'd212, 1'b1, 1'b1);
        repeat (123) frame_tick();
        expect_state("edge_last_inside", 2'b01, 10'd632, 10'd212, 10'd639, 10'd219, 1'b1, 1'b1);
        frame_tick();
        expect_state("edge_exit_right", 2'b00, 10'd632, 10'd212, 10'd639, 10'd219, 1'b0, 1'b1);
        frame_tick();
        expect_state("no_queued_shot", 2'b00, 10'd632, 10'd212, 10'd639, 10'd219, 1'b0, 1'b1);

        // Spawn rejections and screen-edge spawns.
        set_tank(10'd100, 10'd4, 3'b001);
        press_fire();
        frame_tick();
        expect_state("spawn_up_reject", 2'b00, 10'd632, 10'd212, 10'd0, 10'd0, 1'b0, 1'b1);
        set_tank(10'd100, 10'd8, 3'b001);
        press_fire();
        frame_tick();
        expect_state("spawn_up_edge", 2'b01, 10'd112, 10'd0, 10'd112, 10'd7, 1'b1, 1'b1);
        frame_tick();
        expect_state("exit_top", 2'b00, 10'd112, 10'd0, 10'd112, 10'd7, 1'b0, 1'b1);
        set_tank(10'd100, 10'd200, 3'b000);
        press_fire();
        frame_tick();
        expect_state("invalid_dir", 2'b00, 10'd112, 10'd0, 10'd0, 10'd0, 1'b0, 1'b1);
        set_tank(10'd100, 10'd440, 3'b100);
        press_fire();
        frame_tick();
        expect_state("spawn_down_edge", 2'b01, 10'd112, 10'd472, 10'd119, 10'd479, 1'b1, 1'b1);
        frame_tick();
        expect_state("exit_bottom", 2'b00, 10'd112, 10'd472, 10'd119, 10'd479, 1'b0, 1'b1);
        set_tank(10'd100, 10'd441, 3'b100);
        press_fire();
        frame_tick();
        expect_state("spawn_down_reject", 2'b00, 10'd112, 10'd472, 10'd0, 10'd0, 1'b0, 1'b1);

        // Enemy kill and impact hold.
        u_if.enemyX = 10'd206; u_if.enemyY = 10'd200; u_if.enemy_alive = 1'b1;
        set_tank(10'd168, 10'd200, 3'b010);
        press_fire();
        frame_tick();
        expect_state("spawn_near_enemy", 2'b01, 10'd200, 10'd212, 10'd200, 10'd212, 1'b1, 1'b1);
        kill_q.push_back("impact");
        frame_tick();
        expect_state("impact_enter", 2'b10, 10'd204, 10'd212, 10'd204, 10'd212, 1'b0, 1'b1);
        press_fire();
        repeat (7) frame_tick();
        expect_state("impact_hold_7", 2'b10, 10'd204, 10'd212, 10'd0, 10'd0, 1'b0, 1'b1);
        frame_tick();
        expect_state("impact_done_8", 2'b00, 10'd204, 10'd212, 10'd0, 10'd0, 1'b0, 1'b1);
        frame_tick();
        expect_state("no_shot_after_impact", 2'b00, 10'd204, 10'd212, 10'd0, 10'd0, 1'b0, 1'b1);
        u_if.enemy_alive = 1'b0;

        // Left toward a wall, passing through the dead enemy.
        u_if.wallX1 = 10'd150; u_if.wallY1 = 10'd210;
        set_tank(10'd300, 10'd200, 3'b011);
        press_fire();
        frame_tick();
        expect_state("spawn_left", 2'b01, 10'd292, 10'd212, 10'd292, 10'd212, 1'b1, 1'b1);
        repeat (19) frame_tick();
        expect_state("before_wall", 2'b01, 10'd216, 10'd212, 10'd223, 10'd219, 1'b1, 1'b1);
        frame_tick();
        expect_state("wall_stop", 2'b00, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0);
        u_if.wallX1 = 10'd560; u_if.wallY1 = 10'd460;

        // Reset during flight.
        set_tank(10'd268, 10'd288, 3'b010);
        press_fire();
        frame_tick();
        expect_state("spawn_300", 2'b01, 10'd300, 10'd300, 10'd300, 10'd300, 1'b1, 1'b1);
        Reset = 1'b1;
        step(1);
        expect_state("reset_in_flight", 2'b00, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b1);
        Reset = 1'b0;
        step(3);

        checks++;
        if ((exp_q.size() != 0) || (kill_q.size() != 0)) begin
            errors++;
            $display("FAIL leftover_expectations: got %0d state / %0d kill pending, want 0 / 0",
                     exp_q.size(), kill_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
